// File: rtl/disp_scan6_pkg.sv
// Shared constants for the HH:MM:SS scanned display: digit indices,
// active-low 7-segment patterns and counter sizing helpers.
package disp_scan6_pkg;

    localparam logic [2:0] DIG_HH = 3'd5;
    localparam logic [2:0] DIG_HL = 3'd4;
    localparam logic [2:0] DIG_MH = 3'd3;
    localparam logic [2:0] DIG_ML = 3'd2;
    localparam logic [2:0] DIG_SH = 3'd1;
    localparam logic [2:0] DIG_SL = 3'd0;

    // Segment patterns are g..a, active-low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic       LIT_LEVEL = 1'b0;
    localparam logic       OFF_LEVEL = 1'b1;
    localparam logic [5:0] AN_NONE   = 6'b111111;

    typedef struct packed {
        logic [3:0] hour_h;
        logic [3:0] hour_l;
        logic [3:0] min_h;
        logic [3:0] min_l;
        logic [3:0] sec_h;
        logic [3:0] sec_l;
    } time_bcd_t;

    // Width able to hold 0..tc, never less than one bit.
    function automatic int cnt_width(input int tc);
        return (tc < 1) ? 1 : $clog2(tc + 1);
    endfunction

    function automatic logic [5:0] an_select(input logic [2:0] idx);
        return AN_NONE ^ (6'b000001 << idx);
    endfunction

endpackage

// File: rtl/disp_scan6_bcd7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 decode
// to a blank digit.
module bcd7seg
    import disp_scan6_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan6.sv
// Six-digit HH.MM.SS common-anode display scanner with frame-coherent
// snapshot, per-digit blinking and hours-tens leading-zero blanking.
module disp_scan6
    import disp_scan6_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    input  logic [5:0] blink_mask,
    input  logic       lz_blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int DWELL      = CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int DW_W       = cnt_width(DWELL - 1);
    localparam int BL_W       = cnt_width(BLINK_HALF - 1);
    localparam logic [DW_W-1:0] DWELL_TC = DW_W'(DWELL - 1);
    localparam logic [BL_W-1:0] BLINK_TC = BL_W'(BLINK_HALF - 1);

    logic [2:0]      r_idx;
    logic [DW_W-1:0] r_dwell;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink_on;
    time_bcd_t       r_snap;
    logic [5:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic            r_frame;

    logic [3:0]      w_digit;
    logic            w_mask_bit;
    logic            w_lz_hit;
    logic            w_blank;
    logic            w_sep;
    logic [6:0]      w_dec;

    always_comb begin
        w_digit    = 4'd0;
        w_mask_bit = 1'b0;
        case (r_idx)
            DIG_HH: begin w_digit = r_snap.hour_h; w_mask_bit = blink_mask[5]; end
            DIG_HL: begin w_digit = r_snap.hour_l; w_mask_bit = blink_mask[4]; end
            DIG_MH: begin w_digit = r_snap.min_h;  w_mask_bit = blink_mask[3]; end
            DIG_ML: begin w_digit = r_snap.min_l;  w_mask_bit = blink_mask[2]; end
            DIG_SH: begin w_digit = r_snap.sec_h;  w_mask_bit = blink_mask[1]; end
            DIG_SL: begin w_digit = r_snap.sec_l;  w_mask_bit = blink_mask[0]; end
            default: begin w_digit = 4'd0; w_mask_bit = 1'b0; end
        endcase
    end

    // Blanking hides segments and dp only; the anode still fires so dwell stays uniform.
    assign w_lz_hit = (r_idx == DIG_HH) && lz_blank && (r_snap.hour_h == 4'd0);
    assign w_blank  = (w_mask_bit && !r_blink_on) || w_lz_hit;
    assign w_sep    = (r_idx == DIG_HL) || (r_idx == DIG_ML);

    bcd7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_idx       <= DIG_HH;
            r_dwell     <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_snap      <= '0;
            r_an        <= AN_NONE;
            r_seg       <= SEG_BLANK;
            r_dp        <= OFF_LEVEL;
            r_frame     <= 1'b0;
        end else begin
            if (r_dwell == DWELL_TC) begin
                r_dwell <= '0;
                if (r_idx == DIG_SL) begin
                    r_idx  <= DIG_HH;
                    r_snap <= {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
                end else begin
                    r_idx <= r_idx - 3'd1;
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end

            if (r_blink_cnt == BLINK_TC) begin
                r_blink_cnt <= '0;
                r_blink_on  <= !r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            r_an    <= an_select(r_idx);
            r_seg   <= w_blank ? SEG_BLANK : w_dec;
            r_dp    <= (w_sep && !w_blank) ? LIT_LEVEL : OFF_LEVEL;
            r_frame <= (r_idx == DIG_HH) && (r_dwell == '0);
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = r_dp;
    assign frame = r_frame;

endmodule

// File: tb/tb_disp_scan6.sv
// Directed bench for disp_scan6 with DWELL=12 and a 60-cycle blink half-period.
module tb_disp_scan6;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] hour_h, hour_l, min_h, min_l, sec_h, sec_l;
    logic [5:0] blink_mask;
    logic       lz_blank;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    typedef struct {
        int         k;
        logic       drv;
        logic [23:0] bcd;
        logic [5:0] mask;
        logic       lz;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } vec_t;

    vec_t vecs[$];

    disp_scan6 #(
        .CLK_HZ   (1200),
        .SCAN_HZ  (100),
        .BLINK_HZ (10)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .hour_h     (hour_h),
        .hour_l     (hour_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .sec_h      (sec_h),
        .sec_l      (sec_l),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame      (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic set_in(input logic [23:0] bcd, input logic [5:0] mask, input logic lz);
        {hour_h, hour_l, min_h, min_l, sec_h, sec_l} = bcd;
        blink_mask = mask;
        lz_blank   = lz;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) begin
            step();
            chk("frame_period", {31'd0, frame}, {31'd0, (cyc % 72) == 0});
        end
    endtask

    task automatic add(input int k, input logic [5:0] a, input logic [6:0] s,
                       input logic d, input logic f);
        vec_t v;
        v.k = k; v.drv = 1'b0; v.bcd = '0; v.mask = '0; v.lz = 1'b0;
        v.an = a; v.seg = s; v.dp = d; v.fr = f;
        vecs.push_back(v);
    endtask

    task automatic add_d(input int k, input logic [5:0] a, input logic [6:0] s,
                         input logic d, input logic f, input logic [23:0] bcd,
                         input logic [5:0] m, input logic lz);
        vec_t v;
        v.k = k; v.drv = 1'b1; v.bcd = bcd; v.mask = m; v.lz = lz;
        v.an = a; v.seg = s; v.dp = d; v.fr = f;
        vecs.push_back(v);
    endtask

    initial begin
        // First frame shows the reset snapshot, second shows 12:34:56.
        add(  0, 6'b011111, 7'h40, 1, 1);
        add( 11, 6'b011111, 7'h40, 1, 0);
        add( 12, 6'b101111, 7'h40, 0, 0);
        add( 30, 6'b110111, 7'h40, 1, 0);
        add( 36, 6'b111011, 7'h40, 0, 0);
        add( 71, 6'b111110, 7'h40, 1, 0);
        add( 72, 6'b011111, 7'h79, 1, 1);
        add( 84, 6'b101111, 7'h24, 0, 0);
        add( 95, 6'b101111, 7'h24, 0, 0);
        add( 96, 6'b110111, 7'h30, 1, 0);
        add(108, 6'b111011, 7'h19, 0, 0);
        add(120, 6'b111101, 7'h12, 1, 0);
        add(132, 6'b111110, 7'h02, 1, 0);
        add(143, 6'b111110, 7'h02, 1, 0);
        add(144, 6'b011111, 7'h79, 1, 1);
        // 23:59:59 captured, then rolled to 00:00:00 mid-frame.
        add_d(150, 6'b011111, 7'h79, 1, 0, 24'h235959, 6'b000000, 0);
        add(216, 6'b011111, 7'h24, 1, 1);
        add(228, 6'b101111, 7'h30, 0, 0);
        add(240, 6'b110111, 7'h12, 1, 0);
        add_d(250, 6'b110111, 7'h12, 1, 0, 24'h000000, 6'b000000, 0);
        add(252, 6'b111011, 7'h10, 0, 0);
        add(264, 6'b111101, 7'h12, 1, 0);
        add(276, 6'b111110, 7'h10, 1, 0);
        add(287, 6'b111110, 7'h10, 1, 0);
        add(288, 6'b011111, 7'h40, 1, 1);
        add(300, 6'b101111, 7'h40, 0, 0);
        // Blink digits 1 and 0 with 08:15:42.
        add_d(348, 6'b111110, 7'h40, 1, 0, 24'h081542, 6'b000011, 0);
        add(408, 6'b111101, 7'h19, 1, 0);
        add(419, 6'b111101, 7'h19, 1, 0);
        add(420, 6'b111110, 7'h7F, 1, 0);
        add(431, 6'b111110, 7'h7F, 1, 0);
        add(432, 6'b011111, 7'h40, 1, 1);
        add(444, 6'b101111, 7'h00, 0, 0);
        add(456, 6'b110111, 7'h79, 1, 0);
        add(468, 6'b111011, 7'h12, 0, 0);
        add(480, 6'b111101, 7'h19, 1, 0);
        add(492, 6'b111110, 7'h24, 1, 0);
        add(552, 6'b111101, 7'h7F, 1, 0);
        add_d(564, 6'b111110, 7'h7F, 1, 0, 24'h081542, 6'b000000, 0);
        // Leading-zero blanking is live; hour_h=1 then shows normally.
        add_d(575, 6'b111110, 7'h24, 1, 0, 24'h081542, 6'b000000, 1);
        add_d(576, 6'b011111, 7'h7F, 1, 1, 24'h181542, 6'b000000, 1);
        add(587, 6'b011111, 7'h7F, 1, 0);
        add(588, 6'b101111, 7'h00, 0, 0);
        // Illegal code on hour_l blanks segments but keeps the separator.
        add_d(648, 6'b011111, 7'h79, 1, 1, 24'h1B1542, 6'b000000, 0);
        add(720, 6'b011111, 7'h79, 1, 1);
        add(732, 6'b101111, 7'h7F, 0, 0);
        add(744, 6'b110111, 7'h79, 1, 0);
        add(756, 6'b111011, 7'h12, 0, 0);
        add(768, 6'b111101, 7'h19, 1, 0);
        add(780, 6'b111110, 7'h24, 1, 0);

        clr = 1'b1;
        set_in(24'h000000, 6'b000000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", {26'd0, an}, {26'd0, 6'b111111});
        chk("rst_seg", {25'd0, seg}, {25'd0, 7'h7F});
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        set_in(24'h123456, 6'b000000, 1'b0);
        clr = 1'b0;

        foreach (vecs[i]) begin
            run_to(vecs[i].k);
            chk("vec_an", {26'd0, an}, {26'd0, vecs[i].an});
            chk("vec_seg", {25'd0, seg}, {25'd0, vecs[i].seg});
            chk("vec_dp", {31'd0, dp}, {31'd0, vecs[i].dp});
            chk("vec_frame", {31'd0, frame}, {31'd0, vecs[i].fr});
            if (vecs[i].drv) set_in(vecs[i].bcd, vecs[i].mask, vecs[i].lz);
        end

        // Reset pulse while digit 2 is lit.
        run_to(830);
        chk("pre_clr_an", {26'd0, an}, {26'd0, 6'b111011});
        clr = 1'b1;
        step();
        chk("clr_an", {26'd0, an}, {26'd0, 6'b111111});
        chk("clr_seg", {25'd0, seg}, {25'd0, 7'h7F});
        chk("clr_dp", {31'd0, dp}, 32'd1);
        chk("clr_frame", {31'd0, frame}, 32'd0);
        clr = 1'b0;
        step();
        chk("restart_an", {26'd0, an}, {26'd0, 6'b011111});
        chk("restart_seg", {25'd0, seg}, {25'd0, 7'h40});
        chk("restart_frame", {31'd0, frame}, 32'd1);
        for (int r = 1; r < 12; r++) begin
            step();
            chk("restart_dwell_an", {26'd0, an}, {26'd0, 6'b011111});
            chk("restart_dwell_frame", {31'd0, frame}, 32'd0);
        end
        step();
        chk("restart_next_an", {26'd0, an}, {26'd0, 6'b101111});
        chk("restart_next_dp", {31'd0, dp}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
